// File: rtl/sp_minmax_reduce.sv
// FP32 min/max vector reduction sequencer: streams N elements through an
// external single-precision min/max comparator and returns one result plus sticky invalid.
module sp_minmax_reduce #(
    parameter int unsigned LEN_W     = 16,
    parameter logic [31:0] CANON_NAN = 32'h7fc0_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_invalid,
    output logic             cmp_start,
    output logic [31:0]      cmp_operand_a,
    output logic [31:0]      cmp_operand_b,
    output logic [2:0]       cmp_func3,
    input  logic [31:0]      cmp_result,
    input  logic             cmp_flag_invalid,
    input  logic             cmp_done
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FIRST   = 3'd1,
        S_WAIT_IN = 3'd2,
        S_CMP     = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_acc_nxt;
    logic [DATA_W-1:0]  r_elem;
    logic [DATA_W-1:0]  w_elem_nxt;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic               r_op;
    logic               w_op_nxt;
    logic               r_sticky;
    logic               w_sticky_nxt;

    logic               r_cfg_ready;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_invalid;
    logic               r_cmp_start;

    logic               w_cfg_ready_nxt;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic [DATA_W-1:0]  w_out_data_nxt;
    logic               w_out_invalid_nxt;
    logic               w_cmp_start_nxt;

    logic               w_in_nan;
    logic               w_in_snan;

    // Only the first element bypasses the comparator, so it is classified here.
    assign w_in_nan  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    assign w_in_snan = w_in_nan && !in_data[22];

    // Next-state, datapath and output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_elem_nxt      = r_elem;
        w_remaining_nxt = r_remaining;
        w_op_nxt        = r_op;
        w_sticky_nxt    = r_sticky;

        unique case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_op_nxt     = cfg_op;
                    w_sticky_nxt = 1'b0;
                    if (cfg_len == LEN_W'(0)) begin
                        w_acc_nxt   = CANON_NAN;
                        w_state_nxt = S_OUT;
                    end else begin
                        w_remaining_nxt = LEN_W'(cfg_len - LEN_W'(1));
                        w_state_nxt     = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                if (in_valid) begin
                    w_acc_nxt    = w_in_nan ? CANON_NAN : in_data;
                    w_sticky_nxt = r_sticky | w_in_snan;
                    w_state_nxt  = (r_remaining == LEN_W'(0)) ? S_OUT : S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    w_elem_nxt  = in_data;
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                if (cmp_done) begin
                    w_acc_nxt       = cmp_result;
                    w_sticky_nxt    = r_sticky | cmp_flag_invalid;
                    w_remaining_nxt = LEN_W'(r_remaining - LEN_W'(1));
                    w_state_nxt     = (r_remaining == LEN_W'(1)) ? S_OUT : S_WAIT_IN;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they track it without a cycle lag.
        w_cfg_ready_nxt   = (w_state_nxt == S_IDLE);
        w_in_ready_nxt    = (w_state_nxt == S_FIRST) || (w_state_nxt == S_WAIT_IN);
        w_out_valid_nxt   = (w_state_nxt == S_OUT);
        w_cmp_start_nxt   = (w_state_nxt == S_CMP);
        w_out_data_nxt    = (w_state_nxt == S_OUT) ? w_acc_nxt : '0;
        w_out_invalid_nxt = (w_state_nxt == S_OUT) ? w_sticky_nxt : 1'b0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_elem        <= '0;
            r_remaining   <= '0;
            r_op          <= 1'b0;
            r_sticky      <= 1'b0;
            r_cfg_ready   <= 1'b1;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_invalid <= 1'b0;
            r_cmp_start   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_elem        <= w_elem_nxt;
            r_remaining   <= w_remaining_nxt;
            r_op          <= w_op_nxt;
            r_sticky      <= w_sticky_nxt;
            r_cfg_ready   <= w_cfg_ready_nxt;
            r_in_ready    <= w_in_ready_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_invalid <= w_out_invalid_nxt;
            r_cmp_start   <= w_cmp_start_nxt;
        end
    end

    assign cfg_ready     = r_cfg_ready;
    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_invalid   = r_out_invalid;
    assign cmp_start     = r_cmp_start;
    assign cmp_operand_a = r_acc;
    assign cmp_operand_b = r_elem;
    assign cmp_func3     = {2'b00, r_op};

endmodule
